// File: rtl/uart_tx_arbiter_pkg.sv
// Shared uart-side definitions: arbiter FSM encoding and one-hot grant codes.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_REQ0 = 2'b01;
  localparam logic [1:0] GRANT_REQ1 = 2'b10;

endpackage

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the uart tx FIFO between two requesters,
// with forced release on maximum packet length or stall timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int MAX_LEN = 16,
  parameter int LEN_BIT = 5,
  parameter int IDLE_TO = 64,
  parameter int TO_BIT  = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic [DBIT-1:0] req0_data,
  input  logic            req0_last,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [DBIT-1:0] req1_data,
  input  logic            req1_last,
  output logic            req1_ready,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  output logic [1:0]      grant,
  output logic            forced_rel
);

  arb_state_t         r_state, w_state_next;
  logic               r_last_served, w_last_served_next;
  logic [LEN_BIT-1:0] r_cnt, w_cnt_inc;
  logic [TO_BIT-1:0]  r_stall, w_stall_inc;
  logic               r_forced, w_forced_next;

  logic               w_granted, w_sel_valid, w_sel_last, w_xfer;
  logic [DBIT-1:0]    w_sel_data;

  // Only the owner's inputs are looked at; the other requester is ignored.
  always_comb begin
    w_granted   = 1'b0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    grant       = GRANT_NONE;
    case (r_state)
      ST_GNT0: begin
        w_granted   = 1'b1;
        w_sel_valid = req0_valid;
        w_sel_last  = req0_last;
        w_sel_data  = req0_data;
        grant       = GRANT_REQ0;
      end
      ST_GNT1: begin
        w_granted   = 1'b1;
        w_sel_valid = req1_valid;
        w_sel_last  = req1_last;
        w_sel_data  = req1_data;
        grant       = GRANT_REQ1;
      end
      default: ;
    endcase
  end

  assign w_xfer      = w_granted & w_sel_valid & ~tx_full;
  assign req0_ready  = (r_state == ST_GNT0) & ~tx_full;
  assign req1_ready  = (r_state == ST_GNT1) & ~tx_full;
  assign wr_uart     = w_xfer;
  assign w_data      = w_sel_data;
  assign forced_rel  = r_forced;
  assign w_cnt_inc   = r_cnt + LEN_BIT'(1);
  assign w_stall_inc = r_stall + TO_BIT'(1);

  always_comb begin
    w_state_next       = r_state;
    w_last_served_next = r_last_served;
    w_forced_next      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // r_last_served = 1 means req1 was served last, so req0 wins a tie.
        if (req0_valid && (!req1_valid || r_last_served)) begin
          w_state_next       = ST_GNT0;
          w_last_served_next = 1'b0;
        end else if (req1_valid) begin
          w_state_next       = ST_GNT1;
          w_last_served_next = 1'b1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (w_xfer && w_sel_last) begin
          w_state_next = ST_IDLE;
        end else if (w_xfer && (w_cnt_inc == LEN_BIT'(MAX_LEN))) begin
          w_state_next  = ST_IDLE;
          w_forced_next = 1'b1;
        end else if (!w_sel_valid && (w_stall_inc == TO_BIT'(IDLE_TO))) begin
          w_state_next  = ST_IDLE;
          w_forced_next = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_last_served <= 1'b1;
      r_cnt         <= '0;
      r_stall       <= '0;
      r_forced      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_last_served <= w_last_served_next;
      r_forced      <= w_forced_next;
      if (w_state_next == ST_IDLE) begin
        r_cnt   <= '0;
        r_stall <= '0;
      end else if (r_state != ST_IDLE) begin
        if (w_xfer) r_cnt <= w_cnt_inc;
        // Backpressure with valid high keeps the stall counter cleared.
        r_stall <= w_sel_valid ? '0 : w_stall_inc;
      end
    end
  end

endmodule
